mem_arbiter: RTL and testbench

Single-port memory arbiter between the request unit (instruction fetch and data access enables) and the unified RAM. It accepts `imemREN`, `dmemREN` and `dmemWEN` with their addresses and store data, and serialises them onto one RAM port. It returns `ihit`/`dhit` pulses to the request unit and datapath when the RAM completes each access. Data accesses have priority, and a bounded starvation counter guarantees instruction fetch progress.

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins arbitration; a saturating counter bounds how long a waiting fetch can be passed over.
module mem_arbiter #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ISTARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [WORD_W-1:0] imemload,
  output logic              ihit,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] dmemload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err,
  output logic [1:0]        dbg_state_o,
  output logic [2:0]        dbg_scnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS   = 2'd2;
  localparam logic [1:0] RAM_ERROR    = 2'd3;
  localparam logic [2:0] ISTARVE_LIM  = 3'(ISTARVE_MAX);

  state_t     state_q, state_d;
  logic [2:0] scnt_q, scnt_d;
  logic       ram_err_q, ram_err_d;
  logic       dreq;
  logic [2:0] scnt_inc;

  assign dreq     = dmemREN | dmemWEN;
  assign scnt_inc = (scnt_q == 3'd7) ? 3'd7 : scnt_q + 3'd1;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      scnt_q    <= 3'd0;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      ram_err_q <= ram_err_d;
    end
  end

  // Handshake: a requester raises its enable(s) and holds address/data until
  // its hit pulse; dropping the enable inside a grant aborts with no hit.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    ram_err_d = ram_err_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    ihit      = 1'b0;
    imemload  = '0;
    dhit      = 1'b0;
    dmemload  = '0;
    case (state_q)
      IDLE: begin
        // scnt counts data grants taken while a fetch was waiting
        if (dreq && (!imemREN || scnt_q < ISTARVE_LIM)) begin
          state_d = DGRANT;
          scnt_d  = imemREN ? scnt_inc : 3'd0;
        end else if (imemREN) begin
          state_d = IGRANT;
          scnt_d  = 3'd0;
        end
      end
      IGRANT: begin
        if (!imemREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = imemaddr;
          if (ramstate == RAM_ACCESS) begin
            ihit     = 1'b1;
            imemload = ramload;
            state_d  = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            ram_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      DGRANT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramWEN   = dmemWEN;
          ramREN   = dmemREN & ~dmemWEN;
          ramaddr  = dmemaddr;
          ramstore = dmemstore;
          if (ramstate == RAM_ACCESS) begin
            dhit     = 1'b1;
            dmemload = ramload;
            state_d  = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            ram_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_err     = ram_err_q;
  assign dbg_state_o = state_q;
  assign dbg_scnt_o  = scnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized requesters,
// all compared cycle by cycle against a transaction-level ownership model.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int SM = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          imemREN, dmemREN, dmemWEN;
  logic [W-1:0]  imemaddr, dmemaddr, dmemstore, ramload;
  logic [1:0]    ramstate;
  logic [W-1:0]  imemload, dmemload, ramaddr, ramstore;
  logic          ihit, dhit, ramREN, ramWEN, ram_err;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_scnt;

  mem_arbiter #(.WORD_W(W), .ADDR_W(W), .ISTARVE_MAX(SM)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err),
    .dbg_state_o(dbg_state), .dbg_scnt_o(dbg_scnt)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = fetch holds the RAM, 2 = data holds the RAM
  int   m_owner = 0;
  int   m_wait  = 0;   // data wins taken while a fetch was pending
  bit   m_err   = 0;
  bit   last_ihit, last_dhit;

  // Compares this cycle's outputs with the model, then advances the model
  // across the coming rising edge. Entered just after a falling edge.
  task automatic tick();
    bit dreq, e_ihit, e_dhit, e_ren, e_wen, held;
    logic [W-1:0] e_addr, e_store, e_iload, e_dload;
    #1;
    dreq = dmemREN | dmemWEN;
    e_ihit = 0; e_dhit = 0; e_ren = 0; e_wen = 0;
    e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
    held = (m_owner == 1) ? imemREN : (m_owner == 2) ? dreq : 1'b0;
    if (m_owner == 1 && held) begin
      e_ren  = 1;
      e_addr = imemaddr;
      if (ramstate == 2'd2) begin e_ihit = 1; e_iload = ramload; end
    end
    if (m_owner == 2 && held) begin
      e_wen   = dmemWEN;
      e_ren   = dmemREN && !dmemWEN;
      e_addr  = dmemaddr;
      e_store = dmemstore;
      if (ramstate == 2'd2) begin e_dhit = 1; e_dload = ramload; end
    end
    check_eq("ihit", ihit, e_ihit);
    check_eq("dhit", dhit, e_dhit);
    check_eq("ramREN", ramREN, e_ren);
    check_eq("ramWEN", ramWEN, e_wen);
    check_eq("ramaddr", ramaddr, e_addr);
    check_eq("ramstore", ramstore, e_store);
    check_eq("imemload", imemload, e_iload);
    check_eq("dmemload", dmemload, e_dload);
    check_eq("ram_err", ram_err, m_err);
    check_eq("scnt", dbg_scnt, m_wait[2:0]);
    last_ihit = e_ihit;
    last_dhit = e_dhit;
    if (!nRST) begin
      m_owner = 0; m_wait = 0; m_err = 0;
    end else if (m_owner == 0) begin
      if (dreq && (!imemREN || m_wait < SM)) begin
        m_owner = 2;
        m_wait  = imemREN ? ((m_wait + 1 > 7) ? 7 : m_wait + 1) : 0;
      end else if (imemREN) begin
        m_owner = 1;
        m_wait  = 0;
      end
    end else if (!held) begin
      m_owner = 0;
    end else if (ramstate == 2'd3) begin
      m_err   = 1;
      m_owner = 0;
    end else if (ramstate == 2'd2) begin
      m_owner = 0;
    end
    @(negedge CLK);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    imemREN = 0; dmemREN = 0; dmemWEN = 0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0;
    ramload = '0; ramstate = 2'd0;
  endtask

  task automatic do_reset();
    nRST = 0;
    repeat (2) tick();
    nRST = 1;
  endtask

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];   // expected grant order: 1 = fetch, 2 = data
  int         i_kind, d_kind;
  bit         i_busy, d_busy;
  int         wen_cycles, ihit_seen;

  initial begin
    nRST = 0;
    idle_inputs();
    repeat (2) @(negedge CLK);

    // reset with random inputs, then quiet idle
    imemREN = 1'($urandom); dmemREN = 1'($urandom); dmemWEN = 1'($urandom);
    imemaddr = $urandom; dmemaddr = $urandom; dmemstore = $urandom;
    ramload = $urandom; ramstate = 2'($urandom);
    do_reset();
    idle_inputs();
    repeat (3) tick();

    // single zero-wait fetch
    imemREN = 1; imemaddr = 32'h40; ramstate = 2'd2; ramload = 32'h8C010004;
    tick();
    #1;
    check_eq("fetch_ren", ramREN, 1'b1);
    check_eq("fetch_addr", ramaddr, 32'h40);
    check_eq("fetch_ihit", ihit, 1'b1);
    check_eq("fetch_load", imemload, 32'h8C010004);
    tick();
    imemREN = 0;
    tick();

    // data write with three BUSY waits
    dmemWEN = 1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF; ramstate = 2'd0;
    wen_cycles = 0; ihit_seen = 0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      ramstate = (c == 4) ? 2'd2 : 2'd1;
      #1;
      wen_cycles += int'(ramWEN);
      ihit_seen  += int'(ihit);
      check_eq($sformatf("wr_dhit_c%0d", c), dhit, c == 4);
      tick();
    end
    check_eq("wr_wen_cycles", wen_cycles, 4);
    check_eq("wr_no_ihit", ihit_seen, 0);
    dmemWEN = 0;
    tick();

    // starvation bound: both requesters held, zero-wait RAM
    exp_q = {2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    imemREN = 1; dmemREN = 1; imemaddr = 32'h80; dmemaddr = 32'h200; ramstate = 2'd2;
    for (int c = 0; c < 10; c++) begin
      ramload = $urandom;
      tick();
      if (last_ihit || last_dhit) begin
        if (exp_q.size() == 0) check_eq("starve_extra_grant", 1, 0);
        else check_eq("starve_order", last_ihit ? 2'd1 : 2'd2, exp_q.pop_front());
      end
    end
    check_eq("starve_left", exp_q.size(), 0);
    #1 check_eq("starve_scnt", dbg_scnt, 3'd0);
    imemREN = 0; dmemREN = 0;
    tick();

    // RAM error during a data grant, then a fetch still completes
    dmemREN = 1; dmemaddr = 32'h300; ramstate = 2'd0;
    tick();
    ramstate = 2'd3;
    #1 check_eq("err_no_dhit", dhit, 1'b0);
    tick();
    dmemREN = 0; imemREN = 1; imemaddr = 32'h84; ramstate = 2'd2; ramload = 32'h12345678;
    #1 check_eq("err_sticky", ram_err, 1'b1);
    check_eq("err_idle_ren", ramREN, 1'b0);
    tick();
    #1 check_eq("err_fetch_ihit", ihit, 1'b1);
    tick();
    imemREN = 0;
    tick();

    // abort by dropping dmemREN during a BUSY wait
    dmemREN = 1; dmemaddr = 32'h400; ramstate = 2'd1;
    tick();
    tick();
    dmemREN = 0;
    #1 check_eq("abort_ren", ramREN, 1'b0);
    check_eq("abort_dhit", dhit, 1'b0);
    tick();

    // reset in the middle of a fetch grant
    imemREN = 1; imemaddr = 32'h88; ramstate = 2'd1;
    tick();
    nRST = 0;
    tick();
    #1 check_eq("midrst_ren", ramREN, 1'b0);
    check_eq("midrst_err", ram_err, 1'b0);
    nRST = 1;
    tick();
    imemREN = 0;
    tick();

    // randomized requesters that obey the hold-until-hit rule
    i_busy = 0; d_busy = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_busy || last_ihit) begin
        i_kind   = $urandom_range(0, 2);
        imemREN  = (i_kind != 0);
        imemaddr = $urandom;
        i_busy   = imemREN;
      end
      if (!d_busy || last_dhit) begin
        d_kind    = $urandom_range(0, 4);
        dmemREN   = (d_kind == 1 || d_kind == 3);
        dmemWEN   = (d_kind == 2 || d_kind == 3);
        dmemaddr  = $urandom;
        dmemstore = $urandom;
        d_busy    = dmemREN | dmemWEN;
      end
      case ($urandom_range(0, 19))
        0:             ramstate = 2'd3;
        1, 2, 3, 4:    ramstate = 2'd0;
        5, 6, 7, 8, 9: ramstate = 2'd1;
        default:       ramstate = 2'd2;
      endcase
      ramload = $urandom;
      nRST = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
